// File: rtl/cordic_pkg.sv
// Constants shared by the vectoring- and rotation-mode CORDIC blocks:
// angle constants in Q3.12 radians and the common control-state encoding.
package cordic_pkg;

    localparam int Pi = 12868;

    localparam int AtanLutDepth = 13;

    // round(atan(2^-i) * 4096), round-half-up
    localparam int AtanLut [AtanLutDepth] = '{
        3217, 1899, 1003, 509, 256, 128, 64, 32, 16, 8, 4, 2, 1
    };

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        DONE = 2'd2
    } cordic_state_e;

    // Beyond the table atan(2^-i) rounds to zero in Q3.12
    function automatic int atan_at(input int idx);
        if (idx >= 0 && idx < AtanLutDepth) begin
            return AtanLut[idx];
        end
        return 0;
    endfunction

endpackage

// File: rtl/cordic_vectoring.sv
// Iterative vectoring-mode CORDIC: drives y toward zero, accumulating the
// angle in z; one micro-rotation per clock, no gain correction.
module cordic_vectoring
    import cordic_pkg::*;
#(
    parameter int Width      = 16,
    parameter int Iterations = 13
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    start_cordic_i,
    input  logic signed [Width-1:0] x0_i,
    input  logic signed [Width-1:0] y0_i,
    input  logic signed [Width-1:0] z0_i,
    output logic signed [Width-1:0] xn_o,
    output logic signed [Width-1:0] yn_o,
    output logic signed [Width-1:0] zn_o,
    output logic                    done_tick_cordic_o,
    output logic                    busy_o
);

    localparam int XW = Width + 2;
    localparam int CW = $clog2(Width);

    cordic_state_e        state_q;
    logic [CW-1:0]        i_q;
    logic signed [XW-1:0] x_q, y_q;
    logic signed [Width-1:0] z_q;

    logic signed [XW-1:0]    x_sh, y_sh, x_nx, y_nx, x_ld, y_ld, x0_ext, y0_ext;
    logic signed [Width-1:0] z_nx, z_ld, atan_q, pi_w;

    assign x0_ext = {{2{x0_i[Width-1]}}, x0_i};
    assign y0_ext = {{2{y0_i[Width-1]}}, y0_i};
    assign pi_w   = Width'(Pi);

    // A left-half-plane vector is turned by pi first so the iterations only
    // ever have to cover +/- pi/2.
    always_comb begin
        x_ld = x0_ext;
        y_ld = y0_ext;
        z_ld = z0_i;
        if (x0_i[Width-1]) begin
            x_ld = -x0_ext;
            y_ld = -y0_ext;
            z_ld = y0_i[Width-1] ? (z0_i - pi_w) : (z0_i + pi_w);
        end
    end

    always_comb begin
        x_sh   = x_q >>> i_q;
        y_sh   = y_q >>> i_q;
        atan_q = Width'(atan_at(int'(i_q)));
        if (!y_q[XW-1]) begin
            x_nx = x_q + y_sh;
            y_nx = y_q - x_sh;
            z_nx = z_q + atan_q;
        end else begin
            x_nx = x_q - y_sh;
            y_nx = y_q + x_sh;
            z_nx = z_q - atan_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            i_q     <= '0;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            xn_o    <= '0;
            yn_o    <= '0;
            zn_o    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_cordic_i) begin
                        x_q     <= x_ld;
                        y_q     <= y_ld;
                        z_q     <= z_ld;
                        i_q     <= '0;
                        state_q <= ITER;
                    end
                end
                ITER: begin
                    x_q <= x_nx;
                    y_q <= y_nx;
                    z_q <= z_nx;
                    i_q <= i_q + CW'(1);
                    // The last micro-rotation goes straight to the outputs
                    if (i_q == CW'(Iterations - 1)) begin
                        xn_o    <= x_nx[Width-1:0];
                        yn_o    <= y_nx[Width-1:0];
                        zn_o    <= z_nx;
                        state_q <= DONE;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign done_tick_cordic_o = (state_q == DONE);
    assign busy_o             = (state_q != IDLE);

endmodule

// File: tb/tb_cordic_vectoring.sv
// Scoreboard bench for cordic_vectoring: stimulus pushes model results,
// a negedge monitor pops and compares on every done pulse.
module tb_cordic_vectoring;

    localparam int W = 16;
    localparam int N = 13;

    typedef struct {
        int x;
        int y;
        int z;
        int cyc;
        bit tol;
        int ax;
        int ytol;
        int az;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic start = 1'b0;
    logic signed [W-1:0] x0 = '0, y0 = '0, z0 = '0;
    logic signed [W-1:0] xn, yn, zn;
    logic done, busy;

    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    exp_t sbq[$];
    int   lut[N];
    int   pi_q;
    int   last_x = 0, last_y = 0, last_z = 0;
    bit   done_prev = 1'b0;

    cordic_vectoring #(.Width(W), .Iterations(N)) dut (
        .clk_i              (clk),
        .rst_ni             (rst_n),
        .start_cordic_i     (start),
        .x0_i               (x0),
        .y0_i               (y0),
        .z0_i               (z0),
        .xn_o               (xn),
        .yn_o               (yn),
        .zn_o               (zn),
        .done_tick_cordic_o (done),
        .busy_o             (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int s16(input int v);
        logic signed [W-1:0] t;
        t = v[W-1:0];
        return int'(t);
    endfunction

    // Plain-integer CORDIC on unbounded ints; in-range operands never
    // overflow, so only the final words need wrapping.
    function automatic void model(input int xi, input int yi, input int zi,
                                  output int xo, output int yo, output int zo);
        int x, y, z, xt;
        x = xi;
        y = yi;
        z = zi;
        if (xi < 0) begin
            x = -xi;
            y = -yi;
            z = (yi >= 0) ? zi + pi_q : zi - pi_q;
        end
        for (int k = 0; k < N; k++) begin
            if (y >= 0) begin
                xt = x + (y >>> k);
                y  = y - (x >>> k);
                z  = z + lut[k];
            end else begin
                xt = x - (y >>> k);
                y  = y + (x >>> k);
                z  = z - lut[k];
            end
            x = xt;
        end
        xo = s16(x);
        yo = s16(y);
        zo = s16(z);
    endfunction

    task automatic check_output(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("[TB] FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic check_tol(input string name, input int act, input int req, input int tol);
        total++;
        if (act > req + tol || act < req - tol) begin
            bad++;
            $display("[TB] FAIL %s actual=%0d required=%0d+/-%0d", name, act, req, tol);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (done) begin
            check_output("done_width", int'(done_prev), 0);
            if (sbq.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL unexpected_done actual=1 required=0 cyc=%0d", cyc);
            end else begin
                e = sbq.pop_front();
                check_output("xn", int'(xn), e.x);
                check_output("yn", int'(yn), e.y);
                check_output("zn", int'(zn), e.z);
                check_output("done_cycle", cyc, e.cyc);
                if (e.tol) begin
                    check_tol("xn_approx", int'(xn), e.ax, 4);
                    check_tol("zn_approx", int'(zn), e.az, 3);
                    if (e.ytol >= 0) check_tol("yn_approx", int'(yn), 0, e.ytol);
                end
            end
            last_x = int'(xn);
            last_y = int'(yn);
            last_z = int'(zn);
        end else if (rst_n) begin
            check_output("xn_hold", int'(xn), last_x);
            check_output("yn_hold", int'(yn), last_y);
            check_output("zn_hold", int'(zn), last_z);
        end
        done_prev = done;
    end

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            total++;
            bad++;
            $display("[TB] FAIL idle_timeout actual=busy required=idle");
        end
    endtask

    task automatic drain();
        int n = 0;
        while (sbq.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (sbq.size() != 0) begin
            total++;
            bad++;
            $display("[TB] FAIL drain_timeout actual=%0d pending required=0", sbq.size());
            sbq.delete();
        end
    endtask

    // Drives one request from a negedge; returns the cycle of its start edge.
    task automatic apply_stimulus(input int xv, input int yv, input int zv,
                                  input bit tol, input int ax, input int ytol,
                                  input int az, output int k);
        exp_t e;
        wait_idle();
        x0 = W'(xv);
        y0 = W'(yv);
        z0 = W'(zv);
        start = 1'b1;
        k = cyc + 1;
        model(xv, yv, zv, e.x, e.y, e.z);
        e.cyc  = k + N;
        e.tol  = tol;
        e.ax   = ax;
        e.ytol = ytol;
        e.az   = az;
        sbq.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        int k;
        exp_t e;
        int xv, yv, zv;

        for (int i = 0; i < N; i++) begin
            lut[i] = $rtoi($floor($atan(2.0 ** (-i)) * 4096.0 + 0.5));
        end
        pi_q = $rtoi($floor(3.14159265358979 * 4096.0 + 0.5));

        #1 rst_n = 1'b0;
        #2;
        check_output("rst_xn", int'(xn), 0);
        check_output("rst_yn", int'(yn), 0);
        check_output("rst_zn", int'(zn), 0);
        check_output("rst_done", int'(done), 0);
        check_output("rst_busy", int'(busy), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        apply_stimulus(4096, 0, 0, 1'b1, 6745, 4, 0, k);
        drain();
        apply_stimulus(4096, 4096, 0, 1'b1, 9539, -1, 3217, k);
        drain();
        apply_stimulus(-4096, 0, 0, 1'b1, 6745, -1, 12868, k);
        drain();
        apply_stimulus(0, -4096, 0, 1'b1, 6745, -1, -6434, k);
        drain();

        // Second request mid-operation must be ignored
        apply_stimulus(5000, -3000, 700, 1'b0, 0, -1, 0, k);
        for (int c = 1; c <= 14; c++) begin
            check_output("busy_during_op", int'(busy), 1);
            if (c == 4) begin
                x0 = W'(-7000);
                y0 = W'(2000);
                z0 = W'(-1234);
                start = 1'b1;
            end
            if (c == 5) start = 1'b0;
            @(negedge clk);
        end
        check_output("busy_after_op", int'(busy), 0);
        drain();

        // Reset in the middle of an operation aborts it
        apply_stimulus(3000, -2000, 100, 1'b0, 0, -1, 0, k);
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_output("abort_xn", int'(xn), 0);
        check_output("abort_yn", int'(yn), 0);
        check_output("abort_zn", int'(zn), 0);
        check_output("abort_busy", int'(busy), 0);
        check_output("abort_done", int'(done), 0);
        sbq.delete();
        last_x = 0;
        last_y = 0;
        last_z = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        apply_stimulus(-6000, -5000, 2000, 1'b0, 0, -1, 0, k);
        drain();

        // Start held high: one result every N+2 cycles
        wait_idle();
        x0 = W'(2500);
        y0 = W'(-7100);
        z0 = W'(321);
        start = 1'b1;
        k = cyc + 1;
        model(2500, -7100, 321, e.x, e.y, e.z);
        e.tol = 1'b0;
        e.ax = 0;
        e.ytol = -1;
        e.az = 0;
        for (int n = 0; n < 4; n++) begin
            e.cyc = k + N + n * (N + 2);
            sbq.push_back(e);
        end
        drain();
        start = 1'b0;
        repeat (3) @(negedge clk);

        for (int t = 0; t < 40; t++) begin
            xv = int'($urandom_range(16382)) - 8191;
            yv = int'($urandom_range(16382)) - 8191;
            zv = s16(int'($urandom));
            apply_stimulus(xv, yv, zv, 1'b0, 0, -1, 0, k);
            if (t % 3 == 0) drain();
        end
        drain();
        repeat (4) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
